pc_fetch_unit: RTL and testbench

Program-counter and fetch-sequencing stage of the single-cycle processor. Holds the PC that addresses instruction memory, whose opcode field drives the control unit. Computes the next PC from the control unit's branch, jump and halt signals. Stalls the machine on IN until a debounced button press, and provides the global write-commit qualifier used by the register file and data memory.

---
 rtl/pc_fetch_unit_if.sv | 30 +++
 rtl/pc_fetch_unit.sv | 77 +++++++
 tb/tb_pc_fetch_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: control-unit/ALU inputs and fetch outputs of the fetch stage.
interface pc_fetch_unit_if #(
  parameter int PC_WIDTH = 10
);
  logic                i_button;
  logic                i_halt;
  logic                i_enable_clock;
  logic                i_control_jump;
  logic                i_beq;
  logic                i_bne;
  logic                i_pc_funct;
  logic                i_zero;
  logic [15:0]         i_branch_imm;
  logic [25:0]         i_jump_addr;
  logic [PC_WIDTH-1:0] o_pc;
  logic [31:0]         o_pc_plus1;
  logic                o_commit;
  logic                o_waiting;
  logic                o_halted;
  modport master (
    output i_button, i_halt, i_enable_clock, i_control_jump, i_beq, i_bne,
           i_pc_funct, i_zero, i_branch_imm, i_jump_addr,
    input  o_pc, o_pc_plus1, o_commit, o_waiting, o_halted
  );
  modport slave (
    input  i_button, i_halt, i_enable_clock, i_control_jump, i_beq, i_bne,
           i_pc_funct, i_zero, i_branch_imm, i_jump_addr,
    output o_pc, o_pc_plus1, o_commit, o_waiting, o_halted
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, next-PC selection, IN stall on a debounced button,
// halt, and the write-commit qualifier for the register file and data memory.
module pc_fetch_unit #(
  parameter int                  PC_WIDTH        = 10,
  parameter int                  DEBOUNCE_CYCLES = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = '0
) (
  input logic            clock,
  input logic            reset,
  pc_fetch_unit_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {RUN, WAIT_IN, HALTED} state_t;
  state_t              r_state, w_next_state;
  logic [PC_WIDTH-1:0] r_pc, w_next_pc, w_pc_inc, w_br_target;
  logic [1:0]          r_sync;
  logic [CW-1:0]       r_cnt;
  logic                r_deb, r_press, r_waiting, r_halted;
  logic                w_commit, w_taken, w_differs, w_settle, w_unused;
  assign w_pc_inc    = r_pc + PC_WIDTH'(1);
  assign w_br_target = w_pc_inc + PC_WIDTH'($signed(bus.i_branch_imm));
  assign w_taken     = (bus.i_beq & bus.i_zero) | (bus.i_bne & ~bus.i_zero);
  assign w_differs   = r_sync[1] != r_deb;
  assign w_settle    = w_differs & (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign w_unused    = ^bus.i_jump_addr[25:PC_WIDTH];
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= RUN;
      r_pc      <= RESET_PC;
      r_sync    <= '0;
      r_deb     <= 1'b0;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_waiting <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pc      <= w_next_pc;
      r_sync    <= {r_sync[0], bus.i_button};
      r_deb     <= w_settle ? r_sync[1] : r_deb;
      r_cnt     <= (w_differs && !w_settle) ? r_cnt + CW'(1) : '0;
      // one-cycle pulse on the debounced 0->1 edge; dropped unless WAIT_IN consumes it
      r_press   <= w_settle & r_sync[1];
      r_waiting <= w_next_state == WAIT_IN;
      r_halted  <= w_next_state == HALTED;
    end
  end
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_commit     = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.i_halt) w_next_state = HALTED;
        else if (!bus.i_enable_clock) w_next_state = WAIT_IN;
        else if (bus.i_pc_funct) begin
          w_commit  = 1'b1;
          w_next_pc = bus.i_control_jump ? bus.i_jump_addr[PC_WIDTH-1:0] :
                      w_taken ? w_br_target : w_pc_inc;
        end
      end
      WAIT_IN: begin
        if (r_press) begin
          w_commit     = 1'b1;
          w_next_pc    = w_pc_inc;
          w_next_state = RUN;
        end
      end
      default: ;
    endcase
  end
  assign bus.o_pc       = r_pc;
  assign bus.o_pc_plus1 = 32'(w_pc_inc);
  assign bus.o_commit   = reset & w_commit;
  assign bus.o_waiting  = r_waiting;
  assign bus.o_halted   = r_halted;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: branch/jump vector table plus stall, debounce, halt and reset sequences.
module tb_pc_fetch_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  pc_fetch_unit_if #(.PC_WIDTH(10)) bus ();
  pc_fetch_unit #(.PC_WIDTH(10), .DEBOUNCE_CYCLES(16), .RESET_PC(10'd0)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
  typedef struct {
    logic [9:0] pc;
    logic       waiting;
    logic       halted;
  } exp_t;
  typedef struct {
    string       nm;
    logic        cj, beq, bne, zero, pf;
    logic [15:0] imm;
    logic [25:0] ja;
    logic        ec;
    logic [9:0]  ep;
  } vec_t;
  exp_t       sb[$];
  vec_t       vt[10];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [9:0] cur;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Checks Commit/PCPlus1 mid-cycle, queues the post-edge expectation, then checks it after the edge.
  task automatic tick(input string nm, input logic ec, input logic [9:0] ep, input logic ew, input logic eh);
    exp_t       e;
    logic [9:0] nx;
    @(negedge clock);
    nx = cur + 10'd1;
    chk({nm, " commit"}, 32'(bus.o_commit), 32'(ec));
    chk({nm, " pcplus1"}, bus.o_pc_plus1, {22'd0, nx});
    sb.push_back('{pc: ep, waiting: ew, halted: eh});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk({nm, " pc"}, 32'(bus.o_pc), 32'(e.pc));
    chk({nm, " waiting"}, 32'(bus.o_waiting), 32'(e.waiting));
    chk({nm, " halted"}, 32'(bus.o_halted), 32'(e.halted));
    cur = e.pc;
  endtask
  task automatic defaults();
    bus.i_halt = 0; bus.i_enable_clock = 1; bus.i_control_jump = 0; bus.i_beq = 0;
    bus.i_bne = 0; bus.i_pc_funct = 1; bus.i_zero = 0; bus.i_branch_imm = '0; bus.i_jump_addr = '0;
  endtask
  task automatic goto_pc(input logic [9:0] p);
    bus.i_control_jump = 1; bus.i_jump_addr = 26'(p);
    tick("goto", 1, p, 0, 0);
    defaults();
  endtask
  function automatic vec_t mk(input string nm, input logic cj, beq, bne, zero, pf,
                              input logic [15:0] imm, input logic [25:0] ja, input logic ec, input logic [9:0] ep);
    vec_t v;
    v.nm = nm; v.cj = cj; v.beq = beq; v.bne = bne; v.zero = zero; v.pf = pf;
    v.imm = imm; v.ja = ja; v.ec = ec; v.ep = ep;
    return v;
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end
  initial begin
    vt[0] = mk("beq_taken",    0, 1, 0, 1, 1, 16'hFFFD, 26'h0,   1, 10'd3);
    vt[1] = mk("beq_not",      0, 1, 0, 0, 1, 16'hFFFD, 26'h0,   1, 10'd6);
    vt[2] = mk("bne_taken",    0, 0, 1, 0, 1, 16'd10,   26'h0,   1, 10'd16);
    vt[3] = mk("bne_not",      0, 0, 1, 1, 1, 16'd10,   26'h0,   1, 10'd6);
    vt[4] = mk("jump_wins",    1, 1, 0, 1, 1, 16'd40,   26'h123, 1, 10'h123);
    vt[5] = mk("both_z0",      0, 1, 1, 0, 1, 16'd4,    26'h0,   1, 10'd10);
    vt[6] = mk("both_z1",      0, 1, 1, 1, 1, 16'd4,    26'h0,   1, 10'd10);
    vt[7] = mk("br_to_zero",   0, 1, 0, 1, 1, 16'hFFFA, 26'h0,   1, 10'd0);
    vt[8] = mk("br_wrap",      0, 1, 0, 1, 1, 16'hFFF9, 26'h0,   1, 10'd1023);
    vt[9] = mk("pcfunct_hold", 1, 1, 0, 1, 0, 16'd4,    26'h77,  0, 10'd5);
    defaults();
    bus.i_button = 0;
    reset = 0;
    repeat (2) @(posedge clock);
    #1;
    cur = 10'd0;
    tick("reset", 0, 10'd0, 0, 0);
    reset = 1;
    for (int i = 0; i < 1025; i++) tick("seq", 1, 10'(i + 1), 0, 0);
    foreach (vt[i]) begin
      goto_pc(10'd5);
      bus.i_control_jump = vt[i].cj; bus.i_beq = vt[i].beq; bus.i_bne = vt[i].bne;
      bus.i_zero = vt[i].zero; bus.i_pc_funct = vt[i].pf; bus.i_branch_imm = vt[i].imm;
      bus.i_jump_addr = vt[i].ja;
      tick(vt[i].nm, vt[i].ec, vt[i].ep, 0, 0);
      defaults();
    end
    goto_pc(10'd7);
    bus.i_enable_clock = 0;
    tick("in_enter", 0, 10'd7, 1, 0);
    bus.i_control_jump = 1; bus.i_jump_addr = 26'd99; bus.i_beq = 1; bus.i_zero = 1;
    for (int i = 0; i < 50; i++) tick("in_wait", 0, 10'd7, 1, 0);
    bus.i_button = 1;
    for (int i = 0; i < 18; i++) tick("in_debounce", 0, 10'd7, 1, 0);
    tick("in_press", 1, 10'd8, 0, 0);
    defaults();
    bus.i_button = 0;
    for (int i = 0; i < 25; i++) tick("release_run", 1, cur + 10'd1, 0, 0);
    bus.i_enable_clock = 0;
    tick("glitch_enter", 0, cur, 1, 0);
    bus.i_button = 1;
    for (int i = 0; i < 10; i++) tick("glitch_hi", 0, cur, 1, 0);
    bus.i_button = 0;
    for (int i = 0; i < 30; i++) tick("glitch_after", 0, cur, 1, 0);
    bus.i_button = 1;
    for (int i = 0; i < 18; i++) tick("held1_deb", 0, cur, 1, 0);
    tick("held1_press", 1, cur + 10'd1, 0, 0);
    tick("held2_enter", 0, cur, 1, 0);
    for (int i = 0; i < 40; i++) tick("held2_hold", 0, cur, 1, 0);
    bus.i_button = 0;
    for (int i = 0; i < 20; i++) tick("held2_release", 0, cur, 1, 0);
    bus.i_button = 1;
    for (int i = 0; i < 18; i++) tick("held2_deb", 0, cur, 1, 0);
    tick("held2_press", 1, cur + 10'd1, 0, 0);
    defaults();
    bus.i_button = 0;
    goto_pc(10'd20);
    bus.i_halt = 1;
    tick("halt_enter", 0, 10'd20, 0, 1);
    bus.i_halt = 0; bus.i_control_jump = 1; bus.i_jump_addr = 26'd300;
    for (int i = 0; i < 100; i++) begin
      bus.i_button = (i >= 10 && i < 60);
      tick("halted", 0, 10'd20, 0, 1);
    end
    defaults();
    reset = 0;
    tick("halt_reset", 0, 10'd0, 0, 0);
    reset = 1;
    bus.i_enable_clock = 0;
    tick("rst_in_enter", 0, 10'd0, 1, 0);
    bus.i_button = 1;
    for (int i = 0; i < 10; i++) tick("rst_in_deb", 0, 10'd0, 1, 0);
    reset = 0;
    bus.i_button = 0;
    tick("rst_mid_deb", 0, 10'd0, 0, 0);
    reset = 1;
    tick("rst_reenter", 0, 10'd0, 1, 0);
    for (int i = 0; i < 20; i++) tick("rst_no_spurious", 0, 10'd0, 1, 0);
    bus.i_enable_clock = 1;
    tick("run_again", 0, 10'd0, 1, 0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
